if_stage: RTL and testbench

Instruction fetch stage; sits directly upstream of the IF/ID buffer (id_buf).
- Holds the 6-bit program counter and a 64x16 instruction memory.
- Each cycle it presents one registered 16-bit instruction plus its PC+1 value to id_buf's in_instr / in_adder1 inputs.
- Honours id_buf's hazard stall, branch redirects from later stages, and a HALT opcode, and keeps a fetch counter.

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/imem_64x16.sv | 24 ++
 rtl/if_stage.sv | 112 +++++++++++
 tb/tb_if_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants, opcode field positions and FSM state type for the
// instruction fetch stage.
package if_stage_pkg;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 16;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;

  localparam logic [3:0]         HALT_OP = 4'hF;
  localparam logic [INSTR_W-1:0] NOP     = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/imem_64x16.sv
// 64x16 instruction memory: synchronous loader write port and a
// combinational read port, so a same-edge write is seen only afterwards.
module imem_64x16
  import if_stage_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [PC_W-1:0]    waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [PC_W-1:0]    raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [2**PC_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage feeding the IF/ID buffer: PC, fetch FSM,
// registered instruction / PC+1 outputs and a saturating fetch counter.
module if_stage
  import if_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_start,
  input  logic               in_haz,
  input  logic               in_branch_taken,
  input  logic [PC_W-1:0]    in_branch_target,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_next,
  output logic               out_valid,
  output logic               out_halted,
  output logic [CNT_W-1:0]   out_fetch_count
);

  state_e             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_next_q;
  logic               valid_q;
  logic               halted_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [INSTR_W-1:0] rdata;
  logic [PC_W-1:0]    pc_inc;
  logic               is_halt;

  imem_64x16 u_imem (
    .clk     (clk),
    .we_i    (imem_we),
    .waddr_i (imem_waddr),
    .wdata_i (imem_wdata),
    .raddr_i (pc_q),
    .rdata_o (rdata)
  );

  assign pc_inc  = pc_q + 1'b1;
  assign is_halt = (rdata[OP_HI:OP_LO] == HALT_OP);

  // Priority inside each state: branch redirect, then stall, then advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= NOP;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          pc_q    <= '0;
          instr_q <= NOP;
          valid_q <= 1'b0;
          if (in_start) begin
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (in_branch_taken) begin
            pc_q    <= in_branch_target;
            instr_q <= NOP;
            valid_q <= 1'b0;
          end else if (!in_haz) begin
            instr_q   <= rdata;
            pc_next_q <= pc_inc;
            valid_q   <= 1'b1;
            pc_q      <= pc_inc;
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (is_halt) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
          end
        end
        HALT: begin
          // The HALT word itself was issued; from here on only bubbles.
          instr_q <= NOP;
          valid_q <= 1'b0;
          if (in_branch_taken) begin
            pc_q     <= in_branch_target;
            state_q  <= FETCH;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          pc_q     <= '0;
          instr_q  <= NOP;
          valid_q  <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_instr       = instr_q;
  assign out_pc_next     = pc_next_q;
  assign out_valid       = valid_q;
  assign out_halted      = halted_q;
  assign out_fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural fetch model pushes the
// expected outputs per edge, which are popped and compared after that edge.
module tb_if_stage;
  import if_stage_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               inStart;
  logic               inHaz;
  logic               inBranchTaken;
  logic [PC_W-1:0]    inBranchTarget;
  logic               imemWe;
  logic [PC_W-1:0]    imemWaddr;
  logic [INSTR_W-1:0] imemWdata;
  logic [INSTR_W-1:0] outInstr;
  logic [PC_W-1:0]    outPcNext;
  logic               outValid;
  logic               outHalted;
  logic [CNT_W-1:0]   outFetchCount;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pcNext;
    logic               valid;
    logic               halted;
    logic [CNT_W-1:0]   cnt;
  } expT;

  expT sbQ[$];

  logic [INSTR_W-1:0] mMem [64];
  state_e             mState;
  logic [PC_W-1:0]    mPc;
  logic [PC_W-1:0]    mPcNext;
  logic [INSTR_W-1:0] mInstr;
  logic [CNT_W-1:0]   mCnt;
  logic               mValid;
  logic               mHalted;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .in_start         (inStart),
    .in_haz           (inHaz),
    .in_branch_taken  (inBranchTaken),
    .in_branch_target (inBranchTarget),
    .imem_we          (imemWe),
    .imem_waddr       (imemWaddr),
    .imem_wdata       (imemWdata),
    .out_instr        (outInstr),
    .out_pc_next      (outPcNext),
    .out_valid        (outValid),
    .out_halted       (outHalted),
    .out_fetch_count  (outFetchCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    mState  = IDLE;
    mPc     = '0;
    mPcNext = '0;
    mInstr  = '0;
    mCnt    = '0;
    mValid  = 1'b0;
    mHalted = 1'b0;
  endtask

  // Behavioural next-state of the fetch stage for one edge; memory is read
  // before the same-edge write lands.
  task automatic modelStep(input logic start, input logic haz, input logic br,
                           input logic [PC_W-1:0] tgt, input logic we,
                           input logic [PC_W-1:0] wa, input logic [INSTR_W-1:0] wd);
    logic [INSTR_W-1:0] word;
    word = mMem[mPc];
    if (mState == IDLE) begin
      mPc = '0; mInstr = '0; mValid = 1'b0;
      if (start) mState = FETCH;
    end else if (mState == HALT) begin
      mInstr = '0; mValid = 1'b0;
      if (br) begin mPc = tgt; mState = FETCH; mHalted = 1'b0; end
    end else if (br) begin
      mPc = tgt; mInstr = '0; mValid = 1'b0;
    end else if (!haz) begin
      mInstr = word; mValid = 1'b1;
      mPcNext = mPc + 6'd1;
      mPc = mPc + 6'd1;
      if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      if (word[15:12] == 4'hF) begin mState = HALT; mHalted = 1'b1; end
    end
    if (we) mMem[wa] = wd;
  endtask

  task automatic compareHead();
    expT e;
    e = sbQ.pop_front();
    checkOutput("valid", 32'(outValid), 32'(e.valid));
    checkOutput("instr", 32'(outInstr), 32'(e.instr));
    checkOutput("halted", 32'(outHalted), 32'(e.halted));
    checkOutput("count", 32'(outFetchCount), 32'(e.cnt));
    if (e.valid) checkOutput("pcNext", 32'(outPcNext), 32'(e.pcNext));
  endtask

  task automatic applyStimulus(input logic start, input logic haz, input logic br,
                               input logic [PC_W-1:0] tgt, input logic we,
                               input logic [PC_W-1:0] wa, input logic [INSTR_W-1:0] wd);
    expT e;
    inStart = start; inHaz = haz; inBranchTaken = br; inBranchTarget = tgt;
    imemWe = we; imemWaddr = wa; imemWdata = wd;
    modelStep(start, haz, br, tgt, we, wa, wd);
    e.instr = mInstr; e.pcNext = mPcNext; e.valid = mValid;
    e.halted = mHalted; e.cnt = mCnt;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    compareHead();
    @(negedge clk);
  endtask

  task automatic cycle(input logic start, input logic haz, input logic br,
                       input logic [PC_W-1:0] tgt);
    applyStimulus(start, haz, br, tgt, 1'b0, 6'd0, 16'h0000);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Instr"}, 32'(outInstr), 32'h0);
    checkOutput({tag, "PcNext"}, 32'(outPcNext), 32'h0);
    checkOutput({tag, "Valid"}, 32'(outValid), 32'h0);
    checkOutput({tag, "Halted"}, 32'(outHalted), 32'h0);
    checkOutput({tag, "Count"}, 32'(outFetchCount), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    inStart = 0; inHaz = 0; inBranchTaken = 0; inBranchTarget = '0;
    imemWe = 0; imemWaddr = '0; imemWdata = '0;
    for (int i = 0; i < 64; i++) mMem[i] = '0;
    modelReset();
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 0, 0, 0, 1, 6'd0, 16'h0564);
    applyStimulus(0, 0, 0, 0, 1, 6'd1, 16'h0155);
    applyStimulus(0, 0, 0, 0, 1, 6'd2, 16'hF000);
    for (int i = 3; i <= 12; i++)
      applyStimulus(0, 0, 0, 0, 1, 6'(i), 16'h1000 | 16'(i));
    applyStimulus(0, 0, 0, 0, 1, 6'd63, 16'h0448);

    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    checkOutput("firstInstr", 32'(outInstr), 32'h0564);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    checkOutput("haltIssued", 32'(outInstr), 32'hF000);
    cycle(0, 0, 0, 0);
    checkOutput("haltState", 32'(outHalted), 32'h1);
    checkOutput("haltCount", 32'(outFetchCount), 32'd3);
    cycle(0, 0, 0, 0);

    cycle(0, 0, 1, 6'd4);
    checkOutput("haltExit", 32'(outHalted), 32'h0);
    cycle(0, 0, 0, 0);
    checkOutput("afterHaltInstr", 32'(outInstr), 32'h1004);

    cycle(0, 0, 1, 6'd0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    checkOutput("stallHold", 32'(outInstr), 32'h0564);
    cycle(0, 0, 0, 0);
    checkOutput("stallRelease", 32'(outInstr), 32'h0155);

    cycle(0, 1, 1, 6'd10);
    checkOutput("branchBubble", 32'(outValid), 32'h0);
    cycle(0, 0, 0, 0);
    checkOutput("branchTarget", 32'(outInstr), 32'h100A);

    cycle(0, 0, 1, 6'd63);
    cycle(0, 0, 0, 0);
    checkOutput("wrapPcNext", 32'(outPcNext), 32'h0);
    cycle(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd1, 16'hABCD);
    checkOutput("readBeforeWrite", 32'(outInstr), 32'h0155);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 6'd3);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    #2 rst = 1'b1;
    #1 checkAllZero("asyncReset");
    #1 rst = 1'b0;
    modelReset();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    checkOutput("restartInstr", 32'(outInstr), 32'h0564);
    cycle(0, 0, 0, 0);
    checkOutput("retainedWrite", 32'(outInstr), 32'hABCD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
